dspl_scan_blink: RTL and testbench

DSPL_SCAN_BLINK -- requirements
Module: dspl_scan_blink

---
 rtl/dspl_scan_blink.sv | 181 ++++++++++++++++++
 tb/tb_dspl_scan_blink.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dspl_scan_blink.sv
`default_nettype none
// ============================================================================
// Module   : dspl_scan_blink
// Brief    : Multiplexed hex display scanner with double buffering, blinking
//            and leading-zero suppression.
// Revision : 1.0
// ============================================================================
module dspl_scan_blink #(
    parameter int NDIG       = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_HALF = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp_en,
    input  logic [NDIG-1:0]   blank,
    input  logic [NDIG-1:0]   blink_mask,
    input  logic              blink_en,
    input  logic              lz_supp,
    input  logic              load,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        dec_ddp,
    output logic              blink_phase
);

    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BL_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PS_W-1:0]  C_PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [BL_W-1:0]  C_BL_LAST  = BL_W'(BLINK_HALF - 1);
    localparam logic [NDIG-1:0]  C_AN_ONE   = NDIG'(1);

    logic [PS_W-1:0]   r_presc;
    logic [IDX_W-1:0]  r_idx;
    logic [BL_W-1:0]   r_bl_cnt;
    logic              r_phase;
    logic [4*NDIG-1:0] r_pend_digits;
    logic [NDIG-1:0]   r_pend_dp;
    logic [NDIG-1:0]   r_pend_blank;
    logic [4*NDIG-1:0] r_act_digits;
    logic [NDIG-1:0]   r_act_dp;
    logic [NDIG-1:0]   r_act_blank;
    logic [NDIG-1:0]   r_an;
    logic [7:0]        r_dec_ddp;

    logic              w_tick;
    logic              w_frame_end;
    logic              w_zero_run;
    logic [NDIG-1:0]   w_supp;
    logic [NDIG-1:0]   w_dark;
    logic [3:0]        w_cur_digit;
    logic              w_cur_dp;
    logic              w_cur_dark;

    assign w_tick      = (r_presc == C_PS_LAST);
    assign w_frame_end = w_tick && (r_idx == C_IDX_LAST);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'b0000001;
            4'h1:    hex_to_seg = 7'b1001111;
            4'h2:    hex_to_seg = 7'b0010010;
            4'h3:    hex_to_seg = 7'b0000110;
            4'h4:    hex_to_seg = 7'b1001100;
            4'h5:    hex_to_seg = 7'b0100100;
            4'h6:    hex_to_seg = 7'b0100000;
            4'h7:    hex_to_seg = 7'b0001111;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0000100;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b1100000;
            4'hC:    hex_to_seg = 7'b0110001;
            4'hD:    hex_to_seg = 7'b1000010;
            4'hE:    hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Active takes the pre-edge pending value, so a load on the boundary
    // cycle lands in pending only and shows up a frame later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '0;
        end else begin
            if (load) begin
                r_pend_digits <= digits;
                r_pend_dp     <= dp_en;
                r_pend_blank  <= blank;
            end
            if (w_frame_end) begin
                r_act_digits <= r_pend_digits;
                r_act_dp     <= r_pend_dp;
                r_act_blank  <= r_pend_blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !blink_en) begin
            r_bl_cnt <= '0;
            r_phase  <= 1'b1;
        end else if (w_tick) begin
            if (r_bl_cnt == C_BL_LAST) begin
                r_bl_cnt <= '0;
                r_phase  <= ~r_phase;
            end else begin
                r_bl_cnt <= r_bl_cnt + 1'b1;
            end
        end
    end

    // Zero run is tracked from the most significant digit downwards.
    always_comb begin
        w_zero_run = lz_supp;
        w_supp     = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (r_act_digits[4*i +: 4] == 4'h0);
            w_supp[i]  = w_zero_run;
        end
    end

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_dark
            assign w_dark[g] = r_act_blank[g]
                             | (blink_en & blink_mask[g] & ~r_phase)
                             | w_supp[g];
        end
    endgenerate

    always_comb begin
        w_cur_digit = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_dark  = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit = r_act_digits[4*i +: 4];
                w_cur_dp    = r_act_dp[i];
                w_cur_dark  = w_dark[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an      <= '1;
            r_dec_ddp <= 8'hFF;
        end else if (w_cur_dark) begin
            r_an      <= '1;
            r_dec_ddp <= 8'hFF;
        end else begin
            r_an      <= ~(C_AN_ONE << r_idx);
            r_dec_ddp <= {hex_to_seg(w_cur_digit), ~w_cur_dp};
        end
    end

    assign an          = r_an;
    assign dec_ddp     = r_dec_ddp;
    assign blink_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_dspl_scan_blink.sv
`default_nettype none
// ============================================================================
// Module   : tb_dspl_scan_blink
// Brief    : Scoreboard bench for dspl_scan_blink (NDIG=4, SCAN_DIV=4,
//            BLINK_HALF=2) with hand-computed expected displays.
// Revision : 1.0
// ============================================================================
module tb_dspl_scan_blink;

    localparam int NDIG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     digits;
    logic [NDIG-1:0] dp_en;
    logic [NDIG-1:0] blank;
    logic [NDIG-1:0] blink_mask;
    logic            blink_en;
    logic            lz_supp;
    logic            load;
    logic [NDIG-1:0] an;
    logic [7:0]      dec_ddp;
    logic            blink_phase;

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [7:0] ddp;
        logic       ph;
        int         stg;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dspl_scan_blink #(
        .NDIG       (NDIG),
        .SCAN_DIV   (4),
        .BLINK_HALF (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_en       (dp_en),
        .blank       (blank),
        .blink_mask  (blink_mask),
        .blink_en    (blink_en),
        .lz_supp     (lz_supp),
        .load        (load),
        .an          (an),
        .dec_ddp     (dec_ddp),
        .blink_phase (blink_phase)
    );

    function automatic string stg_name(input int s);
        case (s)
            0:       return "reset";
            1:       return "scan";
            2:       return "buffer";
            3:       return "decode";
            4:       return "blink";
            default: return "rst_prio";
        endcase
    endfunction

    task automatic push_exp(input int at, input logic [3:0] a, input logic [7:0] d,
                            input logic p, input int stg);
        exp_t e;
        e.at  = at;
        e.an  = a;
        e.ddp = d;
        e.ph  = p;
        e.stg = stg;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: the display presents a new sample every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.at < cyc) begin
                    errors++;
                    $display("FAIL %s cyc=%0d sample missed (now %0d)", stg_name(e.stg), e.at, cyc);
                end else if (an !== e.an || dec_ddp !== e.ddp || blink_phase !== e.ph) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got an=%h ddp=%h ph=%b want an=%h ddp=%h ph=%b",
                             stg_name(e.stg), cyc, an, dec_ddp, blink_phase, e.an, e.ddp, e.ph);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        rst        = 1'b0;
        digits     = 16'h0000;
        dp_en      = '0;
        blank      = '0;
        blink_mask = '0;
        blink_en   = 1'b0;
        lz_supp    = 1'b0;
        load       = 1'b0;

        push_exp(3, 4'hF, 8'hFF, 1'b1, 0);
        wait_cyc(3);
        rst = 1'b1;
        b   = 4;
        b2  = b + 160;

        push_exp(b + 0,  4'hE, 8'h03, 1'b1, 1);
        push_exp(b + 3,  4'hE, 8'h03, 1'b1, 1);
        push_exp(b + 4,  4'hD, 8'h03, 1'b1, 1);
        push_exp(b + 8,  4'hB, 8'h03, 1'b1, 1);
        push_exp(b + 12, 4'h7, 8'h03, 1'b1, 1);
        push_exp(b + 15, 4'h7, 8'h03, 1'b1, 1);
        push_exp(b + 16, 4'hE, 8'h03, 1'b1, 1);

        push_exp(b + 28, 4'h7, 8'h03, 1'b1, 2);
        push_exp(b + 32, 4'hE, 8'h99, 1'b1, 2);
        push_exp(b + 36, 4'hD, 8'h0D, 1'b1, 2);
        push_exp(b + 40, 4'hB, 8'h25, 1'b1, 2);
        push_exp(b + 44, 4'h7, 8'h9F, 1'b1, 2);
        push_exp(b + 48, 4'hE, 8'h99, 1'b1, 2);
        push_exp(b + 64, 4'hE, 8'h01, 1'b1, 2);
        push_exp(b + 68, 4'hD, 8'h1F, 1'b1, 2);
        push_exp(b + 72, 4'hB, 8'h41, 1'b1, 2);
        push_exp(b + 76, 4'h7, 8'h49, 1'b1, 2);

        push_exp(b + 80,  4'hE, 8'h00, 1'b1, 3);
        push_exp(b + 84,  4'hD, 8'h03, 1'b1, 3);
        push_exp(b + 88,  4'hF, 8'hFF, 1'b1, 3);
        push_exp(b + 92,  4'hF, 8'hFF, 1'b1, 3);
        push_exp(b + 96,  4'hE, 8'h00, 1'b1, 3);
        push_exp(b + 100, 4'hF, 8'hFF, 1'b1, 3);
        push_exp(b + 104, 4'hB, 8'h03, 1'b1, 3);

        push_exp(b + 112, 4'hE, 8'h00, 1'b1, 4);
        push_exp(b + 116, 4'hF, 8'hFF, 1'b0, 4);
        push_exp(b + 118, 4'hF, 8'hFF, 1'b0, 4);
        push_exp(b + 120, 4'hB, 8'h03, 1'b0, 4);
        push_exp(b + 124, 4'h7, 8'h03, 1'b1, 4);
        push_exp(b + 128, 4'hE, 8'h00, 1'b1, 4);
        push_exp(b + 132, 4'hF, 8'hFF, 1'b0, 4);
        push_exp(b + 136, 4'hB, 8'h03, 1'b1, 4);
        push_exp(b + 144, 4'hE, 8'h00, 1'b1, 4);
        push_exp(b + 148, 4'hD, 8'h03, 1'b1, 4);

        push_exp(b + 159, 4'hF, 8'hFF, 1'b1, 5);
        push_exp(b2 + 0,  4'hE, 8'h03, 1'b1, 5);
        push_exp(b2 + 4,  4'hD, 8'h03, 1'b1, 5);
        push_exp(b2 + 16, 4'hE, 8'h03, 1'b1, 5);
        push_exp(b2 + 28, 4'h7, 8'h03, 1'b1, 5);

        // Mid-frame load, then a load on the frame boundary cycle.
        wait_cyc(b + 19); digits = 16'h1234; load = 1'b1;
        wait_cyc(b + 20); load = 1'b0;
        wait_cyc(b + 46); digits = 16'h5678; load = 1'b1;
        wait_cyc(b + 47); load = 1'b0;
        wait_cyc(b + 67); digits = 16'h0008; dp_en = 4'b0001; load = 1'b1;
        wait_cyc(b + 68); load = 1'b0;
        wait_cyc(b + 85); lz_supp = 1'b1;
        wait_cyc(b + 101); lz_supp = 1'b0; blink_mask = 4'b0010;
        wait_cyc(b + 107); blink_en = 1'b1;
        wait_cyc(b + 135); blink_en = 1'b0;
        // Reset lands on a frame-boundary tick together with a load.
        wait_cyc(b + 158); rst = 1'b0; load = 1'b1; digits = 16'hABCD; dp_en = 4'hF;
        wait_cyc(b + 159); rst = 1'b1; load = 1'b0;

        wait_cyc(b2 + 30);
        if (sb.size() != 0) begin
            $display("FAIL leftover: %0d samples never compared, want 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
